// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states, default widths.
// Optional build macro MD_EARLY_OUT_EN is interpreted in md_unit.
package md_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = 5;

    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_FIX  = 2'b11
    } md_state_e;

    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/md_div_core.sv
// Restoring-divider datapath: one quotient bit per enabled cycle on unsigned magnitudes.
module md_div_core
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quo_o,
    output logic [WIDTH-1:0] rem_o
);

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] rem_d;

    // The remainder is always below the divisor, so the shifted partial
    // remainder fits in WIDTH+1 bits and the difference fits back in WIDTH.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign ge      = shifted >= {1'b0, dvs_q};
    assign rem_d   = ge ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dvs_q <= divisor_i;
        end else if (en_i) begin
            rem_q <= rem_d;
            quo_q <= {quo_q[WIDTH-2:0], ge};
        end
    end

    assign quo_o = quo_q;
    assign rem_o = rem_q;

endmodule

// File: rtl/md_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and single-cycle MTHI/MTLO.
// Define MD_EARLY_OUT_EN to let MUL finish once the remaining multiplier bits are zero.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);

    md_state_e          state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q, done_q, dz_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [2*WIDTH-1:0] mcand_q, prod_q;
    logic [WIDTH-1:0]   mplier_q;
    logic               neg_q_q, neg_r_q, is_mul_q, dz_pend_q;

    logic               accept, sgn, a_neg, b_neg, is_div_op;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] prod_d, prod_fix;
    logic               mul_last;
    logic [WIDTH-1:0]   div_quo, div_rem, quo_fix, rem_fix;

    // Busy is only ever high outside IDLE, so accept implies the FSM is idle.
    assign accept    = start && !busy_q;
    assign sgn       = md_is_signed(md_op);
    assign a_neg     = sgn && busA[WIDTH-1];
    assign b_neg     = sgn && busB[WIDTH-1];
    assign abs_a     = a_neg ? (~busA + 1'b1) : busA;
    assign abs_b     = b_neg ? (~busB + 1'b1) : busB;
    assign is_div_op = (md_op == MD_DIV) || (md_op == MD_DIVU);

    assign prod_d = prod_q + (mplier_q[0] ? mcand_q : '0);

`ifdef MD_EARLY_OUT_EN
    assign mul_last = (cnt_q == '1) || (mplier_q[WIDTH-1:1] == '0);
`else
    assign mul_last = (cnt_q == '1);
`endif

    assign prod_fix = neg_q_q ? (~prod_q + 1'b1) : prod_q;
    assign quo_fix  = neg_q_q ? (~div_quo + 1'b1) : div_quo;
    assign rem_fix  = neg_r_q ? (~div_rem + 1'b1) : div_rem;

    md_div_core #(.WIDTH(WIDTH)) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept && is_div_op),
        .en_i       (state_q == S_DIV),
        .dividend_i (abs_a),
        .divisor_i  (abs_b),
        .quo_o      (div_quo),
        .rem_o      (div_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            mcand_q   <= '0;
            prod_q    <= '0;
            mplier_q  <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            is_mul_q  <= 1'b0;
            dz_pend_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        case (md_op)
                            MD_MTHI: hi_q <= busA;
                            MD_MTLO: lo_q <= busA;
                            MD_MULT, MD_MULTU: begin
                                busy_q    <= 1'b1;
                                state_q   <= S_MUL;
                                cnt_q     <= '0;
                                mcand_q   <= {{WIDTH{1'b0}}, abs_a};
                                mplier_q  <= abs_b;
                                prod_q    <= '0;
                                neg_q_q   <= a_neg ^ b_neg;
                                is_mul_q  <= 1'b1;
                                dz_pend_q <= 1'b0;
                            end
                            MD_DIV, MD_DIVU: begin
                                busy_q    <= 1'b1;
                                cnt_q     <= '0;
                                neg_q_q   <= a_neg ^ b_neg;
                                neg_r_q   <= a_neg;
                                is_mul_q  <= 1'b0;
                                dz_pend_q <= (busB == '0);
                                state_q   <= (busB == '0) ? S_FIX : S_DIV;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    prod_q   <= prod_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (mul_last) state_q <= S_FIX;
                end
                S_DIV: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == '1) state_q <= S_FIX;
                end
                S_FIX: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                    if (dz_pend_q) begin
                        dz_q <= 1'b1;
                    end else if (is_mul_q) begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign div_zero  = dz_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: arithmetic reference model with an edge-count timing model feeding a scoreboard queue.
module tb_md_unit;
    import md_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   md_op = 3'b111;
    logic [W-1:0] busA = '0, busB = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;
    logic [1:0]   dbg_state;

    always #5 clk = ~clk;

    md_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op),
        .busA(busA), .busB(busB), .busy(busy), .done(done),
        .div_zero(div_zero), .hi(hi), .lo(lo), .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;
    logic [64:0] exp_q[$];
    int lat_q[$];
    int edge_cnt = 0;
    int free_edge = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0;
    int busy_run = 0;
    logic [64:0] mon_e;
    int mon_l;

    always @(posedge clk) edge_cnt++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run = 0;
        end else begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 expected=0");
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_l = lat_q.pop_front();
                    chk("done_hi", hi, mon_e[63:32]);
                    chk("done_lo", lo, mon_e[31:0]);
                    chk("div_zero", div_zero, mon_e[64]);
                    chk("busy_cycles", busy_run, mon_l);
                end
            end else if (div_zero) begin
                checks++;
                errors++;
                $display("FAIL div_zero_without_done actual=1 expected=0");
            end
            busy_run = busy ? busy_run + 1 : 0;
        end
    end

    function automatic int mul_iters(input logic [W-1:0] b);
        int n;
`ifdef MD_EARLY_OUT_EN
        n = 1;
        for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
`else
        n = W;
`endif
        return n;
    endfunction

    // Drive one request for a single edge; the model decides from edge timing whether it is accepted.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int k, lat;
        logic sg;
        logic [63:0] ua, ub, p;
        longint sa, sb, q, r;
        logic [W-1:0] mb;
        md_op = op; busA = a; busB = b; start = 1'b1;
        k = edge_cnt + 1;
        if (k >= free_edge) begin
            sg = (op == MD_MULT) || (op == MD_DIV);
            ua = sg ? {{32{a[31]}}, a} : {32'b0, a};
            ub = sg ? {{32{b[31]}}, b} : {32'b0, b};
            sa = longint'(ua);
            sb = longint'(ub);
            case (op)
                MD_MTHI: m_hi = a;
                MD_MTLO: m_lo = a;
                MD_MULT, MD_MULTU: begin
                    p = ua * ub;
                    mb = (sg && b[31]) ? (0 - b) : b;
                    lat = mul_iters(mb) + 1;
                    m_hi = p[63:32];
                    m_lo = p[31:0];
                    exp_q.push_back({1'b0, m_hi, m_lo});
                    lat_q.push_back(lat);
                    free_edge = k + lat + 1;
                end
                MD_DIV, MD_DIVU: begin
                    if (b == '0) begin
                        lat = 1;
                        exp_q.push_back({1'b1, m_hi, m_lo});
                    end else begin
                        lat = W + 1;
                        q = sa / sb;
                        r = sa % sb;
                        m_lo = q[31:0];
                        m_hi = r[31:0];
                        exp_q.push_back({1'b0, m_hi, m_lo});
                    end
                    lat_q.push_back(lat);
                    free_edge = k + lat + 1;
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1 start = 1'b0;
        md_op = 3'b111;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout actual=busy expected=idle");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 300);
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL wait_done_timeout actual=0 expected=1");
        end
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_hi"}, hi, m_hi);
        chk({tag, "_lo"}, lo, m_lo);
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'(32'h0000_FFFF & $urandom);
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int n;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_div_zero", div_zero, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_state", dbg_state, S_IDLE);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(MD_MULT, 32'hFFFF_FFFF, 32'h2);   wait_idle(); check_regs("mult");
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'h2);  wait_idle(); check_regs("multu");
        issue(MD_DIV, 32'hFFFF_FFF9, 32'h2);    wait_idle(); check_regs("div");
        issue(MD_DIVU, 32'hFFFF_FFF9, 32'h2);   wait_idle(); check_regs("divu");

        issue(MD_MTHI, 32'h1234, 32'h0);
        chk("mthi_busy", busy, 0);
        issue(MD_MTLO, 32'h5678, 32'h0);
        check_regs("mthi_mtlo");
        issue(MD_DIVU, 32'hDEAD_BEEF, 32'h0);   wait_idle(); check_regs("div_zero");

        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle(); check_regs("div_ovf");

        // A start while busy is dropped; a start in the done cycle is taken.
        issue(MD_MULT, 32'h0001_2345, 32'hFFFF_FF00);
        repeat (5) @(posedge clk);
        #1;
        issue(MD_MTLO, 32'hAAAA, 32'h0);
        wait_done();
        issue(MD_MULTU, 32'h0000_0007, 32'h0000_0009);
        wait_idle(); check_regs("back_to_back");

        issue(MD_MULT, 32'h1357_9BDF, 32'h2468_ACE0);
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        lat_q.delete();
        m_hi = '0; m_lo = '0; free_edge = 0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        chk("abort_state", dbg_state, S_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(MD_MULTU, 32'hCAFE_F00D, 32'h1);  wait_idle(); check_regs("mul_b1");
        issue(MD_MULTU, 32'hCAFE_F00D, 32'h0);  wait_idle(); check_regs("mul_b0");
        issue(MD_MULT, 32'h0000_0003, 32'hFFFF_FFFF); wait_idle(); check_regs("mul_neg1");

        for (int i = 0; i < 60; i++) begin
            issue(3'($urandom_range(0, 7)), rnd_val(), rnd_val());
            repeat ($urandom_range(0, 40)) @(posedge clk);
            #1;
        end

        n = 0;
        while ((exp_q.size() != 0 || busy === 1'b1) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d expected=0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
        check_regs("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
